// File: rtl/tpu_controller_if.sv
// Instruction and unit-control bundle between the TPU controller and its datapath.
interface tpu_controller_if;
  logic [31:0] instr_data;
  logic        sys_busy;
  logic        vpu_busy;
  logic        dma_busy;
  logic        wt_busy;
  logic        pc_cnt;
  logic        ir_ld;
  logic        sys_start;
  logic        vpu_start;
  logic        dma_start;
  logic        ub_rd_en;
  logic        ub_wr_en;
  logic [8:0]  ub_rd_addr;
  logic [8:0]  ub_wr_addr;
  logic        ub_buf_sel;
  logic        acc_buf_sel;
  logic        wt_buf_sel;
  logic        pipeline_stall;
  logic [1:0]  current_stage;

  // Controller side
  modport master (
    input  instr_data, sys_busy, vpu_busy, dma_busy, wt_busy,
    output pc_cnt, ir_ld, sys_start, vpu_start, dma_start,
           ub_rd_en, ub_wr_en, ub_rd_addr, ub_wr_addr,
           ub_buf_sel, acc_buf_sel, wt_buf_sel,
           pipeline_stall, current_stage
  );

  // Datapath / program-memory side
  modport slave (
    output instr_data, sys_busy, vpu_busy, dma_busy, wt_busy,
    input  pc_cnt, ir_ld, sys_start, vpu_start, dma_start,
           ub_rd_en, ub_wr_en, ub_rd_addr, ub_wr_addr,
           ub_buf_sel, acc_buf_sel, wt_buf_sel,
           pipeline_stall, current_stage
  );
endinterface

// File: rtl/tpu_controller.sv
// TPU instruction sequencer: fetch/decode/execute with hazard stall and
// double-buffer select management.
module tpu_controller (
  input  logic             clk,
  input  logic             rst,
  tpu_controller_if.master bus
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_DECODE  = 2'b01,
    ST_EXECUTE = 2'b10,
    ST_WAIT    = 2'b11
  } stage_t;

  typedef enum logic [5:0] {
    OP_NOP       = 6'h00,
    OP_RD_HOST   = 6'h01,
    OP_WR_HOST   = 6'h02,
    OP_RD_WEIGHT = 6'h03,
    OP_MATMUL    = 6'h10,
    OP_RELU      = 6'h18,
    OP_SYNC      = 6'h30
  } opcode_t;

  stage_t      stage_q, stage_d;
  logic [31:0] ir_q, ir_d;
  logic        ub_sel_q, ub_sel_d;
  logic        acc_sel_q, acc_sel_d;
  logic        wt_sel_q, wt_sel_d;

  logic [5:0]  opcode;
  logic [7:0]  arg1;
  logic [7:0]  arg2;
  logic [7:0]  arg3;
  logic        hazard;

  // Flag bits ir_q[1:0] are reserved and deliberately not decoded.
  assign opcode = ir_q[31:26];
  assign arg1   = ir_q[25:18];
  assign arg2   = ir_q[17:10];
  assign arg3   = ir_q[9:2];

  // State, instruction register and buffer selects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q   <= ST_FETCH;
      ir_q      <= '0;
      ub_sel_q  <= 1'b0;
      acc_sel_q <= 1'b0;
      wt_sel_q  <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      ir_q      <= ir_d;
      ub_sel_q  <= ub_sel_d;
      acc_sel_q <= acc_sel_d;
      wt_sel_q  <= wt_sel_d;
    end
  end

  // Hazard for the instruction held in IR
  always_comb begin
    hazard = 1'b0;
    case (opcode)
      OP_RD_HOST,
      OP_WR_HOST:   hazard = bus.dma_busy;
      OP_RD_WEIGHT: hazard = bus.wt_busy | bus.dma_busy;
      OP_MATMUL:    hazard = bus.sys_busy;
      OP_RELU:      hazard = bus.vpu_busy;
      OP_SYNC:      hazard = (arg1[0] & bus.sys_busy) | (arg1[1] & bus.vpu_busy) |
                             (arg1[2] & bus.dma_busy) | (arg1[3] & bus.wt_busy);
      default:      hazard = 1'b0;
    endcase
  end

  // Next-stage logic and per-stage control decode
  always_comb begin
    stage_d            = stage_q;
    ir_d               = ir_q;
    ub_sel_d           = ub_sel_q;
    acc_sel_d          = acc_sel_q;
    wt_sel_d           = wt_sel_q;
    bus.pc_cnt         = 1'b0;
    bus.ir_ld          = 1'b0;
    bus.sys_start      = 1'b0;
    bus.vpu_start      = 1'b0;
    bus.dma_start      = 1'b0;
    bus.ub_rd_en       = 1'b0;
    bus.ub_wr_en       = 1'b0;
    bus.pipeline_stall = 1'b0;
    case (stage_q)
      ST_FETCH: begin
        bus.ir_ld  = 1'b1;
        bus.pc_cnt = 1'b1;
        ir_d       = bus.instr_data;
        stage_d    = ST_DECODE;
      end
      ST_DECODE: begin
        stage_d = hazard ? ST_WAIT : ST_EXECUTE;
      end
      ST_WAIT: begin
        bus.pipeline_stall = 1'b1;
        if (!hazard) stage_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        stage_d = ST_FETCH;
        case (opcode)
          OP_RD_HOST:   bus.dma_start = 1'b1;
          OP_WR_HOST: begin
            bus.dma_start = 1'b1;
            bus.ub_rd_en  = 1'b1;
          end
          OP_RD_WEIGHT: bus.dma_start = 1'b1;
          OP_MATMUL: begin
            bus.sys_start = 1'b1;
            bus.ub_rd_en  = 1'b1;
          end
          OP_RELU: begin
            bus.vpu_start = 1'b1;
            bus.ub_wr_en  = 1'b1;
          end
          OP_SYNC: begin
            ub_sel_d  = ub_sel_q  ^ arg3[0];
            acc_sel_d = acc_sel_q ^ arg3[1];
            wt_sel_d  = wt_sel_q  ^ arg3[2];
          end
          default: ;
        endcase
      end
      default: stage_d = ST_FETCH;
    endcase
  end

  // Continuous address and status outputs
  always_comb begin
    bus.ub_rd_addr    = {ub_sel_q, arg1};
    bus.ub_wr_addr    = {ub_sel_q, arg2};
    bus.ub_buf_sel    = ub_sel_q;
    bus.acc_buf_sel   = acc_sel_q;
    bus.wt_buf_sel    = wt_sel_q;
    bus.current_stage = stage_q;
  end

endmodule

// File: tb/tb_tpu_controller.sv
// Self-checking bench for tpu_controller: table of instructions with busy
// patterns; expected EXECUTE results pushed to a scoreboard and checked by
// a negedge monitor, plus a reset-during-WAIT sequence.
module tb_tpu_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tpu_controller_if bus ();

  tpu_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  busy;     // {wt, dma, vpu, sys}
    int          bcyc;     // busy held from DECODE for this many cycles
    logic        bexec;    // raise sys_busy during EXECUTE
    logic [4:0]  strobes;  // {sys_start, vpu_start, dma_start, ub_rd_en, ub_wr_en}
    logic [8:0]  rd_addr;
    logic [8:0]  wr_addr;
    int          waits;
    logic [2:0]  sels;     // {wt, acc, ub} after the instruction
  } vec_t;

  vec_t vecs[17];
  vec_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] strobe_vec();
    return {bus.sys_start, bus.vpu_start, bus.dma_start, bus.ub_rd_en, bus.ub_wr_en};
  endfunction

  // Monitor: legal stage flow, idle outputs, EXECUTE results against scoreboard
  int         wait_cnt = 0;
  logic       sel_pend = 1'b0;
  logic [2:0] sel_exp  = '0;
  logic       have_prev = 1'b0;
  logic [1:0] prev_stage = '0;

  always @(negedge clk) begin
    if (rst) begin
      wait_cnt  = 0;
      sel_pend  = 1'b0;
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        case (prev_stage)
          2'b00: check("flow_fetch", {30'd0, bus.current_stage}, 32'd1);
          2'b01: check("flow_decode", {31'd0, bus.current_stage[1]}, 32'd1);
          2'b10: check("flow_exec", {30'd0, bus.current_stage}, 32'd0);
          default: check("flow_wait", {31'd0, bus.current_stage[1]}, 32'd1);
        endcase
      end
      have_prev  = 1'b1;
      prev_stage = bus.current_stage;
      if (bus.current_stage == 2'b10) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL exec_unexpected: EXECUTE with strobes 0x%0h, none expected", strobe_vec());
        end else begin
          vec_t e;
          e = sb.pop_front();
          check({e.name, "_strobes"}, {27'd0, strobe_vec()}, {27'd0, e.strobes});
          check({e.name, "_rd_addr"}, {23'd0, bus.ub_rd_addr}, {23'd0, e.rd_addr});
          check({e.name, "_wr_addr"}, {23'd0, bus.ub_wr_addr}, {23'd0, e.wr_addr});
          check({e.name, "_waits"}, wait_cnt, e.waits);
          check({e.name, "_exec_stall"}, {31'd0, bus.pipeline_stall}, 32'd0);
          sel_exp  = e.sels;
          sel_pend = 1'b1;
        end
        wait_cnt = 0;
      end else begin
        check("idle_strobes", {27'd0, strobe_vec()}, 32'd0);
        check("stall", {31'd0, bus.pipeline_stall}, {31'd0, bus.current_stage == 2'b11});
        check("fetch_ctl", {30'd0, bus.ir_ld, bus.pc_cnt}, {30'd0, {2{bus.current_stage == 2'b00}}});
        if (bus.current_stage == 2'b11) wait_cnt++;
        if (bus.current_stage == 2'b00 && sel_pend) begin
          check("buf_sels", {29'd0, bus.wt_buf_sel, bus.acc_buf_sel, bus.ub_buf_sel}, {29'd0, sel_exp});
          sel_pend = 1'b0;
        end
      end
    end
  end

  task automatic set_busy(input logic [3:0] m);
    bus.sys_busy = m[0];
    bus.vpu_busy = m[1];
    bus.dma_busy = m[2];
    bus.wt_busy  = m[3];
  endtask

  // Issue one instruction from a FETCH cycle and wait for the next FETCH
  task automatic run_vec(input vec_t v);
    int  cyc;
    logic done;
    bus.instr_data = v.instr;
    if (v.bcyc > 0) set_busy(v.busy);
    sb.push_back(v);
    cyc  = 0;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) bus.instr_data = 32'hFFFF_FFFF;
      if (cyc == v.bcyc + 1) set_busy(4'h0);
      if (bus.current_stage == 2'b10 && v.bexec) bus.sys_busy = 1'b1;
      if (bus.current_stage == 2'b00 && sb.size() == 0) begin
        set_busy(4'h0);
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: instruction did not complete within 60 cycles", v.name);
      sb.delete();
      set_busy(4'h0);
    end
  endtask

  initial begin
    vecs[0]  = '{"nop",          32'h0000_0000, 4'h0, 0, 1'b0, 5'b00000, 9'h000, 9'h000, 0, 3'b000};
    vecs[1]  = '{"matmul",       32'h4000_8010, 4'h0, 0, 1'b0, 5'b10010, 9'h000, 9'h020, 0, 3'b000};
    vecs[2]  = '{"relu",         32'h6081_0010, 4'h0, 0, 1'b0, 5'b01001, 9'h020, 9'h040, 0, 3'b000};
    vecs[3]  = '{"relu_stall",   32'h6081_0010, 4'h2, 4, 1'b0, 5'b01001, 9'h020, 9'h040, 4, 3'b000};
    vecs[4]  = '{"matmul_vbusy", 32'h4000_8010, 4'h2, 3, 1'b0, 5'b10010, 9'h000, 9'h020, 0, 3'b000};
    vecs[5]  = '{"sync_ub",      32'hC00C_0004, 4'h1, 3, 1'b0, 5'b00000, 9'h003, 9'h000, 3, 3'b001};
    vecs[6]  = '{"matmul_ubsel", 32'h4000_8010, 4'h0, 0, 1'b0, 5'b10010, 9'h100, 9'h120, 0, 3'b001};
    vecs[7]  = '{"rdhost",       32'h0400_0040, 4'h0, 0, 1'b0, 5'b00100, 9'h100, 9'h100, 0, 3'b001};
    vecs[8]  = '{"rdhost_stall", 32'h0400_0040, 4'h4, 2, 1'b0, 5'b00100, 9'h100, 9'h100, 2, 3'b001};
    vecs[9]  = '{"wrhost_stall", 32'h0800_0000, 4'h4, 1, 1'b0, 5'b00110, 9'h100, 9'h100, 1, 3'b001};
    vecs[10] = '{"rdwt_wt",      32'h0C00_0000, 4'h8, 2, 1'b0, 5'b00100, 9'h100, 9'h100, 2, 3'b001};
    vecs[11] = '{"rdwt_dma",     32'h0C00_0000, 4'h4, 1, 1'b0, 5'b00100, 9'h100, 9'h100, 1, 3'b001};
    vecs[12] = '{"sync_all",     32'hC03C_0018, 4'h4, 2, 1'b0, 5'b00000, 9'h10F, 9'h100, 2, 3'b111};
    vecs[13] = '{"matmul_xbusy", 32'h4000_8010, 4'h0, 0, 1'b1, 5'b10010, 9'h100, 9'h120, 0, 3'b111};
    vecs[14] = '{"bad_opcode",   32'hFC00_0000, 4'hF, 2, 1'b0, 5'b00000, 9'h100, 9'h100, 0, 3'b111};
    vecs[15] = '{"sync_vmask",   32'hC008_0000, 4'h1, 2, 1'b0, 5'b00000, 9'h102, 9'h100, 0, 3'b111};
    vecs[16] = '{"sync_toggle",  32'hC000_000C, 4'h0, 0, 1'b0, 5'b00000, 9'h100, 9'h100, 0, 3'b100};

    bus.instr_data = '0;
    set_busy(4'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stage",   {30'd0, bus.current_stage}, 32'd0);
    check("rst_fetch",   {30'd0, bus.ir_ld, bus.pc_cnt}, 32'd3);
    check("rst_strobes", {26'd0, strobe_vec(), bus.pipeline_stall}, 32'd0);
    check("rst_addrs",   {14'd0, bus.ub_rd_addr, bus.ub_wr_addr}, 32'd0);
    check("rst_sels",    {29'd0, bus.wt_buf_sel, bus.acc_buf_sel, bus.ub_buf_sel}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // Reset mid-WAIT: SYNC on sys with all toggles, aborted while stalled
    bus.instr_data = 32'hC004_001C;
    bus.sys_busy   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_wait", {30'd0, bus.current_stage}, 32'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_stage",   {30'd0, bus.current_stage}, 32'd0);
    check("mid_rst_sels",    {29'd0, bus.wt_buf_sel, bus.acc_buf_sel, bus.ub_buf_sel}, 32'd0);
    check("mid_rst_strobes", {26'd0, strobe_vec(), bus.pipeline_stall}, 32'd0);
    bus.sys_busy   = 1'b0;
    bus.instr_data = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    run_vec('{"post_rst_nop", 32'h0000_0000, 4'h0, 0, 1'b0, 5'b00000, 9'h000, 9'h000, 0, 3'b000});

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tpu_controller.md
# tpu_controller

Instruction sequencer for the TPU datapath. Latches one 32-bit instruction at a time from the instruction port and steps it through a fetch/decode/execute pipeline. Issues one-cycle start strobes and unified-buffer (UB) access controls to the systolic array, vector unit (VPU), DMA and weight loader. Stalls on unit-busy hazards and manages the double-buffer select bits.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- instr_data  in  32  instruction word: opcode[31:26], arg1[25:18], arg2[17:10], arg3[9:2], flags[1:0] (flags reserved, ignored).
- sys_busy, vpu_busy, dma_busy, wt_busy  in  1 each  unit busy levels.
- pc_cnt  out  1  advance program counter.
- ir_ld  out  1  instruction register load.
- sys_start, vpu_start, dma_start  out  1 each  one-cycle unit start strobes.
- ub_rd_en, ub_wr_en  out  1 each  UB read/write enables.
- ub_rd_addr, ub_wr_addr  out  9 each  UB addresses.
- ub_buf_sel, acc_buf_sel, wt_buf_sel  out  1 each  double-buffer selects.
- pipeline_stall  out  1  controller waiting on a hazard.
- current_stage  out  2  stage: 00 FETCH, 01 DECODE, 10 EXECUTE, 11 WAIT.

## Operation
- Internal state: 2-bit stage register, 32-bit IR, three buffer-select flops.
- Stage sequence:
  - FETCH: ir_ld=1, pc_cnt=1; IR <= instr_data; go to DECODE.
  - DECODE: if the hazard for IR is true, go to WAIT; otherwise go to EXECUTE.
  - WAIT: pipeline_stall=1; stay while the hazard is true; go to EXECUTE in the cycle after it clears.
  - EXECUTE: assert the opcode's strobes; go to FETCH.
- Opcodes, with EXECUTE outputs and hazard condition:
  - 0x00 NOP: no strobes; hazard none.
  - 0x01 RD_HOST_MEM: dma_start; hazard dma_busy.
  - 0x02 WR_HOST_MEM: dma_start, ub_rd_en; hazard dma_busy.
  - 0x03 RD_WEIGHT: dma_start; hazard wt_busy | dma_busy.
  - 0x10 MATMUL: sys_start, ub_rd_en (arg1 = UB src, arg2 = acc dst, arg3 = length); hazard sys_busy.
  - 0x18 RELU: vpu_start, ub_wr_en (arg1 = acc src, arg2 = UB dst, arg3 = length); hazard vpu_busy.
  - 0x30 SYNC: no strobes; hazard is any busy selected by arg1 mask (bit0 sys, bit1 vpu, bit2 dma, bit3 wt). On leaving EXECUTE, toggle per arg3: bit0 ub_buf_sel, bit1 acc_buf_sel, bit2 wt_buf_sel.
  - Any other opcode: executes as NOP.
- Address outputs are driven continuously and are meaningful only while the matching enable is high:
  - ub_rd_addr = {ub_buf_sel, IR.arg1}.
  - ub_wr_addr = {ub_buf_sel, IR.arg2}.
- All strobes, enables, ir_ld and pc_cnt are combinational decodes of stage and IR. They are 0 in every stage not listed above.

## Timing
- Reset (asynchronous, any stage): stage=FETCH, IR=0, all buffer selects 0.
  - Outputs during reset: ir_ld=1 and pc_cnt=1 (FETCH decode); every other output 0, addresses 0.
- Unstalled instruction: exactly 3 cycles. FETCH at edge n, DECODE n+1, EXECUTE n+2, next FETCH n+3.
- Each strobe is high for exactly one cycle per instruction, never repeated during WAIT.
- Stall: WAIT lasts as long as the hazard holds.
  - A hazard that clears during cycle k makes cycle k+1 EXECUTE.
  - Busy inputs are sampled in DECODE and WAIT only. A busy rising during EXECUTE does not affect the current instruction.
- instr_data is sampled only on the FETCH edge; changes at other times are ignored.
- Buffer-select toggles take effect on the edge leaving EXECUTE. In that same EXECUTE cycle, the addresses still use the old select.
- Reset asserted mid-WAIT or mid-EXECUTE aborts the instruction: no strobe, no toggle.

## Test plan
- Reset, release, NOP (0x00000000):
  - ir_ld and pc_cnt pulse in FETCH; stages cycle 00→01→10; all strobes stay 0.
- MATMUL 0x40008010 with sys_busy=0:
  - EXECUTE cycle shows sys_start=1, ub_rd_en=1, ub_rd_addr=0x000, ub_buf_sel=0 for one cycle.
- RELU 0x60810010:
  - vpu_start=1, ub_wr_en=1, ub_wr_addr=0x040 in EXECUTE.
  - Repeat with vpu_busy=1 for 4 cycles: stage 11 and pipeline_stall=1 for those cycles; vpu_start once, after the release.
- SYNC 0xC00C0004 with sys_busy=1 for 3 cycles:
  - pipeline_stall high until the busy drops.
  - After EXECUTE: ub_buf_sel=1, acc_buf_sel=0, wt_buf_sel=0; a following MATMUL gives ub_rd_addr=0x100.
- RD_HOST_MEM 0x04000040:
  - dma_start=1 one cycle, ub_buf_sel unchanged, no UB enables.
  - With dma_busy high: stall until it drops.
- Assert rst during WAIT:
  - Immediate return to stage 00, all selects 0, no start strobe issued.
